// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter.
// Upstream logic pushes bytes into an internal FIFO at clock rate. The serializer
// drains the FIFO onto the serial line with no idle gap between frames. The frame
// format is 8 data bits, LSB first, with optional even or odd parity and one or
// two stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          i_Rst_L,
  input  logic                          i_wr_en,
  input  logic [7:0]                    i_wr_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_overflow,
  output logic                          o_tx_serial,
  output logic                          o_tx_active,
  output logic                          o_tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Reset synchronizer.
  // Assertion takes effect at once. Release reaches the core logic two clock
  // edges later, so the release is aligned to the clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  // Reset synchronizer register: asynchronous clear, then shift in ones.
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          overflow;

  assign full  = (level == DEPTH_LVL);
  assign empty = (level == '0);
  // A pop in the same cycle does not free a slot for the push.
  assign push  = i_wr_en && !full;
  assign head  = mem[rd_ptr];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  // Pointers, level and overflow flag.
  // Both pointers are powers-of-two wide, so they wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= i_wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer
  // ---------------------------------------------------------------------------
  state_t        state,      state_next;
  logic [CW-1:0] cnt,        cnt_next;
  logic [2:0]    bit_idx,    bit_next;
  logic          stop_idx,   stop_next;
  logic [7:0]    shift,      shift_next;
  logic          parity_bit, parity_next;
  logic          serial,     serial_next;
  logic          active,     active_next;
  logic          done,       done_next;
  logic          bit_end;

  assign bit_end = (cnt == CNT_MAX);

  // Serializer state register.
  // The line level is computed one cycle ahead and registered here, so the
  // output is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      serial     <= 1'b1;
      active     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_next;
      stop_idx   <= stop_next;
      shift      <= shift_next;
      parity_bit <= parity_next;
      serial     <= serial_next;
      active     <= active_next;
      done       <= done_next;
    end
  end

  // Next-state logic: bit timing, frame sequencing and FIFO pops.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    bit_next    = bit_idx;
    stop_next   = stop_idx;
    shift_next  = shift;
    parity_next = parity_bit;
    serial_next = serial;
    active_next = active;
    done_next   = 1'b0;
    pop         = 1'b0;

    case (state)
      IDLE: begin
        serial_next = 1'b1;
        cnt_next    = '0;
        if (!empty) begin
          pop         = 1'b1;
          shift_next  = head;
          parity_next = (^head) ^ PAR_ODD;
          active_next = 1'b1;
          serial_next = 1'b0;
          state_next  = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_next    = '0;
          bit_next    = '0;
          serial_next = shift[0];
          state_next  = DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (bit_idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              serial_next = parity_bit;
              state_next  = PARITY;
            end else begin
              stop_next   = 1'b0;
              serial_next = 1'b1;
              state_next  = STOP;
            end
          end else begin
            bit_next    = bit_idx + 3'd1;
            shift_next  = {1'b0, shift[7:1]};
            serial_next = shift[1];
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          cnt_next    = '0;
          stop_next   = 1'b0;
          serial_next = 1'b1;
          state_next  = STOP;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          cnt_next = '0;
          if (stop_idx == STOP_LAST) begin
            done_next = 1'b1;
            if (!empty) begin
              // Chain straight into the next frame with no idle bit.
              pop         = 1'b1;
              shift_next  = head;
              parity_next = (^head) ^ PAR_ODD;
              serial_next = 1'b0;
              state_next  = START;
            end else begin
              active_next = 1'b0;
              serial_next = 1'b1;
              state_next  = IDLE;
            end
          end else begin
            stop_next = stop_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        serial_next = 1'b1;
        active_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_level     = level;
  assign o_overflow  = overflow;
  assign o_tx_serial = serial;
  assign o_tx_active = active;
  assign o_tx_done   = done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo.
// Four instances are built with CLKS_PER_BIT=4:
//   0 = 8N1, 1 = 8E1, 2 = 8O1, 3 = 8N2.
module tb_uart_tx_fifo;

  logic       clk;
  logic       i_Rst_L;
  logic [3:0] wr_en;
  logic [7:0] wr_data;
  logic [3:0] full_v, empty_v, ovf_v, ser_v, act_v, done_v;
  logic [4:0] lvl_v [4];

  int compared = 0;
  int failed   = 0;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          npush;
    int          nbits;
    logic [23:0] pattern;
    string       name;
  } vec_t;

  vec_t vecs[8];

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .i_Rst_L(i_Rst_L), .i_wr_en(wr_en[0]), .i_wr_data(wr_data),
    .o_full(full_v[0]), .o_empty(empty_v[0]), .o_level(lvl_v[0]), .o_overflow(ovf_v[0]),
    .o_tx_serial(ser_v[0]), .o_tx_active(act_v[0]), .o_tx_done(done_v[0]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .clk(clk), .i_Rst_L(i_Rst_L), .i_wr_en(wr_en[1]), .i_wr_data(wr_data),
    .o_full(full_v[1]), .o_empty(empty_v[1]), .o_level(lvl_v[1]), .o_overflow(ovf_v[1]),
    .o_tx_serial(ser_v[1]), .o_tx_active(act_v[1]), .o_tx_done(done_v[1]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .clk(clk), .i_Rst_L(i_Rst_L), .i_wr_en(wr_en[2]), .i_wr_data(wr_data),
    .o_full(full_v[2]), .o_empty(empty_v[2]), .o_level(lvl_v[2]), .o_overflow(ovf_v[2]),
    .o_tx_serial(ser_v[2]), .o_tx_active(act_v[2]), .o_tx_done(done_v[2]));

  uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .STOP_BITS(2)) dut_s2 (
    .clk(clk), .i_Rst_L(i_Rst_L), .i_wr_en(wr_en[3]), .i_wr_data(wr_data),
    .o_full(full_v[3]), .o_empty(empty_v[3]), .o_level(lvl_v[3]), .o_overflow(ovf_v[3]),
    .o_tx_serial(ser_v[3]), .o_tx_active(act_v[3]), .o_tx_done(done_v[3]));

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and keep the tallies.
  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse reset low for two cycles, then let the synchronizer release.
  task automatic doReset();
    @(negedge clk);
    i_Rst_L = 1'b0;
    repeat (2) @(negedge clk);
    i_Rst_L = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Push one table byte (npush times) and watch the whole serial frame.
  // Sample index c=0 is the first cycle of the start bit, two edges after the first push.
  task automatic applyStimulus(input vec_t v);
    int len;
    int bad;
    int act_bad;
    int dones;
    logic [23:0] obs;
    logic [23:0] pat;
    logic expb;
    len = v.nbits * 4;
    bad = 0; act_bad = 0; dones = 0; obs = '0; pat = v.pattern;
    @(negedge clk);
    wr_data = v.data;
    wr_en[v.sel] = 1'b1;
    for (int k = 0; k < v.npush; k++) begin
      @(negedge clk);
      if (k == 0 && v.npush == 1) begin
        checkOutput({v.name, " level after push"}, int'(lvl_v[v.sel]), 1);
        checkOutput({v.name, " empty after push"}, int'(empty_v[v.sel]), 0);
      end
    end
    wr_en[v.sel] = 1'b0;
    for (int c = 0; c <= len; c++) begin
      if (c > 0 || v.npush == 1) @(negedge clk);
      if (c < len) begin
        expb = pat[c/4];
        if (ser_v[v.sel] !== expb) bad++;
        if (c % 4 == 2) obs[c/4] = ser_v[v.sel];
        if (act_v[v.sel] !== 1'b1) act_bad++;
        if (done_v[v.sel] === 1'b1) dones++;
      end else begin
        checkOutput({v.name, " done at frame end"}, int'(done_v[v.sel]), 1);
        checkOutput({v.name, " active at frame end"}, int'(act_v[v.sel]), 0);
        checkOutput({v.name, " line idle after frame"}, int'(ser_v[v.sel]), 1);
      end
    end
    checkOutput({v.name, " bit pattern"}, int'(obs), int'(pat));
    checkOutput({v.name, " bad line samples"}, bad, 0);
    checkOutput({v.name, " active gaps"}, act_bad, 0);
    checkOutput({v.name, " early done pulses"}, dones, v.npush - 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int bad;
    int act_bad;
    int done_bad;
    int idle_bad;
    int c;
    int k;
    int pos;
    logic [9:0] fb;
    logic [7:0] bytes3 [3];

    i_Rst_L = 1'b1;
    wr_en   = '0;
    wr_data = '0;

    // Expected patterns, LSB = first bit on the line (start bit).
    vecs[0] = '{0, 8'h55, 1, 10, 24'h0002AA, "8N1 0x55"};
    vecs[1] = '{0, 8'hA3, 1, 10, 24'h000346, "8N1 0xA3"};
    vecs[2] = '{1, 8'h07, 1, 11, 24'h00060E, "8E1 0x07"};
    vecs[3] = '{2, 8'h07, 1, 11, 24'h00040E, "8O1 0x07"};
    vecs[4] = '{1, 8'h00, 1, 11, 24'h000400, "8E1 0x00"};
    vecs[5] = '{1, 8'h81, 1, 11, 24'h000502, "8E1 0x81"};
    vecs[6] = '{2, 8'h00, 1, 11, 24'h000600, "8O1 0x00"};
    vecs[7] = '{3, 8'hFF, 2, 22, 24'h3FF7FE, "8N2 0xFF x2"};

    // Reset state.
    #2 i_Rst_L = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset serial",   int'(ser_v[0]),   1);
    checkOutput("reset active",   int'(act_v[0]),   0);
    checkOutput("reset done",     int'(done_v[0]),  0);
    checkOutput("reset overflow", int'(ovf_v[0]),   0);
    checkOutput("reset empty",    int'(empty_v[0]), 1);
    checkOutput("reset full",     int'(full_v[0]),  0);
    checkOutput("reset level",    int'(lvl_v[0]),   0);
    i_Rst_L = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven single frames and the two-stop-bit back-to-back pair.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Fill the FIFO while the first frame is on the wire.
    // The 17th byte fills slot 16, and 0xAA is then rejected.
    // All 17 frames must follow one another with no idle gap.
    bad = 0; act_bad = 0; done_bad = 0; idle_bad = 0;
    for (int j = 0; j < 725; j++) begin
      @(negedge clk);
      c = j - 2;
      if (j == 17) begin
        checkOutput("fill full",  int'(full_v[0]), 1);
        checkOutput("fill level", int'(lvl_v[0]),  16);
        checkOutput("fill no overflow yet", int'(ovf_v[0]), 0);
      end
      if (j == 18) begin
        checkOutput("overflow pulse",      int'(ovf_v[0]), 1);
        checkOutput("level after reject",  int'(lvl_v[0]), 16);
      end
      if (j == 19) checkOutput("overflow pulse width", int'(ovf_v[0]), 0);
      if (c >= 0 && c < 680) begin
        k   = c / 40;
        pos = c % 40;
        fb  = {1'b1, k[7:0], 1'b0};
        if (ser_v[0] !== fb[pos/4]) bad++;
        if (act_v[0] !== 1'b1) act_bad++;
        if (pos == 20) checkOutput($sformatf("level frame %0d", k), int'(lvl_v[0]), (k == 0) ? 16 : 16 - k);
        if (pos == 39) begin
          checkOutput($sformatf("burst frame %0d", k), bad, 0);
          bad = 0;
        end
      end
      if (c >= 0 && c <= 680) begin
        if (done_v[0] !== ((c > 0 && c % 40 == 0) ? 1'b1 : 1'b0)) done_bad++;
      end
      if (c == 680) begin
        checkOutput("burst active end", int'(act_v[0]),   0);
        checkOutput("burst empty end",  int'(empty_v[0]), 1);
      end
      if (c > 680 && ser_v[0] !== 1'b1) idle_bad++;
      if (j <= 16) begin
        wr_en[0] = 1'b1;
        wr_data  = j[7:0];
      end else if (j == 17) begin
        wr_en[0] = 1'b1;
        wr_data  = 8'hAA;
      end else begin
        wr_en[0] = 1'b0;
      end
    end
    checkOutput("burst active gaps", act_bad,  0);
    checkOutput("burst done timing", done_bad, 0);
    checkOutput("0xAA never sent",   idle_bad, 0);

    // Push on the very cycle of a pop while full: rejected. Push one cycle later: accepted.
    for (int j = 0; j < 46; j++) begin
      @(negedge clk);
      if (j == 41) begin
        checkOutput("drain level before pop", int'(lvl_v[0]), 16);
        checkOutput("drain full before pop",  int'(full_v[0]), 1);
        checkOutput("drain no overflow",      int'(ovf_v[0]),  0);
      end
      if (j == 42) begin
        checkOutput("pop-cycle push overflow", int'(ovf_v[0]), 1);
        checkOutput("pop-cycle level",         int'(lvl_v[0]), 15);
      end
      if (j == 43) begin
        checkOutput("next push no overflow", int'(ovf_v[0]),  0);
        checkOutput("next push level",       int'(lvl_v[0]),  16);
        checkOutput("next push full",        int'(full_v[0]), 1);
      end
      if (j <= 16) begin
        wr_en[0] = 1'b1;
        wr_data  = j[7:0];
      end else if (j == 41) begin
        wr_en[0] = 1'b1;
        wr_data  = 8'hC1;
      end else if (j == 42) begin
        wr_en[0] = 1'b1;
        wr_data  = 8'hC2;
      end else begin
        wr_en[0] = 1'b0;
      end
    end
    doReset();
    checkOutput("flushed level", int'(lvl_v[0]), 0);

    // Mid-frame reset during data bit 3 of 0xF0, with two bytes still queued.
    bytes3[0] = 8'hF0;
    bytes3[1] = 8'h11;
    bytes3[2] = 8'h22;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 3) checkOutput("queued level", int'(lvl_v[0]), 2);
      if (j == 19) begin
        checkOutput("line low in bit 3", int'(ser_v[0]), 0);
        checkOutput("active in bit 3",   int'(act_v[0]), 1);
        i_Rst_L = 1'b0;
        #1;
        checkOutput("abort serial", int'(ser_v[0]),   1);
        checkOutput("abort active", int'(act_v[0]),   0);
        checkOutput("abort level",  int'(lvl_v[0]),   0);
        checkOutput("abort empty",  int'(empty_v[0]), 1);
      end
      if (j < 3) begin
        wr_en[0] = 1'b1;
        wr_data  = bytes3[j];
      end else begin
        wr_en[0] = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    i_Rst_L = 1'b1;
    idle_bad = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (ser_v[0] !== 1'b1 || act_v[0] !== 1'b0 || done_v[0] !== 1'b0 || lvl_v[0] !== 5'd0) idle_bad++;
    end
    checkOutput("idle after abort", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
